image_downscale: RTL and testbench

- Parametrised image down-scaler for the image-processing pipeline.
- Reads a source frame from a synchronous-read pixel memory and writes a reduced frame to a destination memory in raster order.
- X and Y factors are independent. Runtime mode selects either decimation (top-left pixel of each block) or box averaging, done per channel with edge replication.
- Sits between the frame-store memories, alongside the other per-frame transform blocks.

---
 rtl/image_downscale.sv | 171 +++++++++++++++++
 tb/tb_image_downscale.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/image_downscale.sv
// Frame down-scaler: walks output pixels in raster order, reads each source block
// from a synchronous-read memory and writes either its top-left pixel or its box average.
module image_downscale #(
  parameter int BPP    = 3,
  parameter int WIDTH  = 30,
  parameter int HEIGHT = 30,
  parameter int FX     = 2,
  parameter int FY     = 2,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  output logic                busy,
  output logic                done,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [8*BPP-1:0]    rd_data,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [8*BPP-1:0]    wr_data
);

  localparam int OUT_W = (WIDTH + FX - 1) / FX;
  localparam int OUT_H = (HEIGHT + FY - 1) / FY;
  localparam int NB    = FX * FY;
  localparam int ACC_W = 8 + $clog2(NB + 1);
  localparam int OXW   = $clog2(OUT_W + 1);
  localparam int OYW   = $clog2(OUT_H + 1);
  localparam int BXW   = $clog2(FX + 1);
  localparam int BYW   = $clog2(FY + 1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_LAST, S_WRITE, S_FIN} state_t;

  state_t                       state_q, state_d;
  logic                         mode_q, mode_d;
  logic [OXW-1:0]               ox_q, ox_d;
  logic [OYW-1:0]               oy_q, oy_d;
  logic [BXW-1:0]               bx_q, bx_d;
  logic [BYW-1:0]               by_q, by_d;
  logic [BPP-1:0][ACC_W-1:0]    acc_q, acc_d;
  logic                         beat_v_q, beat_v_d;
  logic                         beat_first_q, beat_first_d;
  logic [ADDR_W-1:0]            wr_addr_q, wr_addr_d;
  logic [8*BPP-1:0]             wr_data_q, wr_data_d;

  logic [BPP-1:0][ACC_W-1:0]    sum;
  logic [8*BPP-1:0]             pix;
  logic                         last_read;
  int                           sx, sy;

  // Read handshake: a rd_en cycle presents rd_addr; rd_data for it is sampled
  // exactly one cycle later (beat_v_q marks that cycle). No backpressure either side.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mode_q       <= 1'b0;
      ox_q         <= '0;
      oy_q         <= '0;
      bx_q         <= '0;
      by_q         <= '0;
      acc_q        <= '0;
      beat_v_q     <= 1'b0;
      beat_first_q <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      ox_q         <= ox_d;
      oy_q         <= oy_d;
      bx_q         <= bx_d;
      by_q         <= by_d;
      acc_q        <= acc_d;
      beat_v_q     <= beat_v_d;
      beat_first_q <= beat_first_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  // Clamping past the right/bottom edge replicates the border pixel for partial blocks.
  always_comb begin
    sx = int'(ox_q) * FX + int'(bx_q);
    sy = int'(oy_q) * FY + int'(by_q);
    if (sx > WIDTH - 1) sx = WIDTH - 1;
    if (sy > HEIGHT - 1) sy = HEIGHT - 1;
    rd_addr = ADDR_W'(sy * WIDTH + sx);
  end

  always_comb begin
    for (int k = 0; k < BPP; k++) begin
      sum[k] = (beat_first_q ? '0 : acc_q[k]) + ACC_W'(rd_data[8*k +: 8]);
      pix[8*k +: 8] = mode_q ? 8'(sum[k] / ACC_W'(NB)) : sum[k][7:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    ox_d         = ox_q;
    oy_d         = oy_q;
    bx_d         = bx_q;
    by_d         = by_q;
    acc_d        = acc_q;
    beat_v_d     = 1'b0;
    beat_first_d = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    last_read    = !mode_q || (bx_q == BXW'(FX - 1) && by_q == BYW'(FY - 1));

    if (beat_v_q) acc_d = sum;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode;
          ox_d    = '0;
          oy_d    = '0;
          bx_d    = '0;
          by_d    = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        beat_v_d     = 1'b1;
        beat_first_d = (bx_q == '0) && (by_q == '0);
        if (last_read) begin
          bx_d    = '0;
          by_d    = '0;
          state_d = S_LAST;
        end else if (bx_q == BXW'(FX - 1)) begin
          bx_d = '0;
          by_d = by_q + BYW'(1);
        end else begin
          bx_d = bx_q + BXW'(1);
        end
      end
      S_LAST: begin
        wr_data_d = pix;
        wr_addr_d = ADDR_W'(int'(oy_q) * OUT_W + int'(ox_q));
        state_d   = S_WRITE;
      end
      S_WRITE: begin
        if (ox_q == OXW'(OUT_W - 1)) begin
          ox_d = '0;
          if (oy_q == OYW'(OUT_H - 1)) begin
            state_d = S_FIN;
          end else begin
            oy_d    = oy_q + OYW'(1);
            state_d = S_READ;
          end
        end else begin
          ox_d    = ox_q + OXW'(1);
          state_d = S_READ;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_FIN);
  assign rd_en   = (state_q == S_READ);
  assign wr_en   = (state_q == S_WRITE);
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_image_downscale.sv
// Bench for image_downscale: three instances (4x4 2x2, 5x3 2x2, 7x2 3x1) with
// bench-side source memories, a frame model and a per-cycle compare process.
module tb_image_downscale;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start_a [3];
  logic        mode_a  [3];
  logic        busy_a  [3];
  logic        done_a  [3];
  logic        rd_en_a [3];
  logic        wr_en_a [3];
  logic [9:0]  rd_addr_a [3];
  logic [9:0]  wr_addr_a [3];
  logic [23:0] wr_data_a [3];

  typedef struct packed {
    logic [9:0]  addr;
    logic [23:0] data;
  } wr_t;

  logic [9:0] exp_q[$];
  wr_t        exp_wr_q[$];

  int n_chk = 0, n_pass = 0;
  int pat = 0, act = 0;
  int cyc = 0, first_rd_cyc = -1, last_wr_cyc = -1;
  int exp_gap = 0, exp_len = 0, done_seen = 0;

  function automatic logic [23:0] pix_of(input int p, input logic [9:0] a);
    logic [7:0] b;
    b = a[7:0];
    if (p == 0) return {b, b, b};
    return {8'(int'(a) * 37 + 5), 8'h00, 8'hFF};
  endfunction

  task automatic cfg(input int i, output int w, output int h, output int fx, output int fy);
    w  = (i == 0) ? 4 : (i == 1) ? 5 : 7;
    h  = (i == 0) ? 4 : (i == 1) ? 3 : 2;
    fx = (i == 2) ? 3 : 2;
    fy = (i == 2) ? 1 : 2;
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W   = (g == 0) ? 4 : (g == 1) ? 5 : 7;
    localparam int H   = (g == 0) ? 4 : (g == 1) ? 3 : 2;
    localparam int PFX = (g == 2) ? 3 : 2;
    localparam int PFY = (g == 2) ? 1 : 2;
    logic [23:0] rd_data = '0;

    image_downscale #(.BPP(3), .WIDTH(W), .HEIGHT(H), .FX(PFX), .FY(PFY), .ADDR_W(10)) u_dut (
      .clk(clk), .rst(rst), .start(start_a[g]), .mode(mode_a[g]),
      .busy(busy_a[g]), .done(done_a[g]),
      .rd_en(rd_en_a[g]), .rd_addr(rd_addr_a[g]), .rd_data(rd_data),
      .wr_en(wr_en_a[g]), .wr_addr(wr_addr_a[g]), .wr_data(wr_data_a[g])
    );

    always @(posedge clk) if (rd_en_a[g]) rd_data <= pix_of(pat, rd_addr_a[g]);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Reference frame: block reads in raster order, per-channel sums, truncating mean.
  task automatic prep(input int inst, input int m, input int p);
    int w, h, fx, fy, ow, oh, nb, sx, sy, a;
    int s [3];
    logic [23:0] px, d;
    cfg(inst, w, h, fx, fy);
    ow = (w + fx - 1) / fx;
    oh = (h + fy - 1) / fy;
    nb = m ? fx * fy : 1;
    exp_q.delete();
    exp_wr_q.delete();
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < ow; ox++) begin
        s = '{0, 0, 0};
        for (int by = 0; by < (m ? fy : 1); by++)
          for (int bx = 0; bx < (m ? fx : 1); bx++) begin
            sx = ox * fx + bx; if (sx > w - 1) sx = w - 1;
            sy = oy * fy + by; if (sy > h - 1) sy = h - 1;
            a  = sy * w + sx;
            exp_q.push_back(10'(a));
            px = pix_of(p, 10'(a));
            for (int c = 0; c < 3; c++) s[c] += int'(px[8*c +: 8]);
          end
        for (int c = 0; c < 3; c++) d[8*c +: 8] = 8'(s[c] / nb);
        exp_wr_q.push_back('{addr: 10'(oy * ow + ox), data: d});
      end
    act          = inst;
    pat          = p;
    exp_gap      = nb + 2;
    exp_len      = ow * oh * (nb + 2);
    first_rd_cyc = -1;
    last_wr_cyc  = -1;
  endtask

  task automatic go(input int inst, input int m);
    @(negedge clk);
    start_a[inst] = 1'b1;
    mode_a[inst]  = m[0];
    @(negedge clk);
    start_a[inst] = 1'b0;
  endtask

  task automatic wait_done();
    int d0;
    d0 = done_seen;
    for (int t = 0; t < 2000 && done_seen == d0; t++) @(negedge clk);
    @(negedge clk);
    if (done_seen == d0) chk("done_timeout", 32'(done_seen), 32'(d0 + 1));
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (i == act) begin
          if (rd_en_a[i] && wr_en_a[i]) chk("rd_wr_overlap", 32'(wr_en_a[i]), 0);
          if (rd_en_a[i]) begin
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            if (exp_q.size() == 0) chk("rd_unexpected", 32'(rd_en_a[i]), 0);
            else chk("rd_addr", 32'(rd_addr_a[i]), 32'(exp_q.pop_front()));
          end
          if (wr_en_a[i]) begin
            if (last_wr_cyc >= 0) chk("wr_gap", 32'(cyc - last_wr_cyc), 32'(exp_gap));
            last_wr_cyc = cyc;
            if (exp_wr_q.size() == 0) chk("wr_unexpected", 32'(wr_en_a[i]), 0);
            else begin
              wr_t e;
              e = exp_wr_q.pop_front();
              chk("wr_addr", 32'(wr_addr_a[i]), 32'(e.addr));
              chk("wr_data", 32'(wr_data_a[i]), 32'(e.data));
            end
          end
          if (done_a[i]) begin
            done_seen++;
            chk("done_len", 32'(cyc - first_rd_cyc), 32'(exp_len));
            chk("rd_left", 32'(exp_q.size()), 0);
            chk("wr_left", 32'(exp_wr_q.size()), 0);
            first_rd_cyc = -1;
          end
        end else begin
          chk("idle_inst_quiet", 32'({busy_a[i], done_a[i], rd_en_a[i], wr_en_a[i]}), 0);
        end
      end
    end
  end

  task automatic chk_zero(input int i, input string tag);
    chk({tag, "_busy"},    32'(busy_a[i]), 0);
    chk({tag, "_done"},    32'(done_a[i]), 0);
    chk({tag, "_rd_en"},   32'(rd_en_a[i]), 0);
    chk({tag, "_wr_en"},   32'(wr_en_a[i]), 0);
    chk({tag, "_rd_addr"}, 32'(rd_addr_a[i]), 0);
    chk({tag, "_wr_addr"}, 32'(wr_addr_a[i]), 0);
    chk({tag, "_wr_data"}, 32'(wr_data_a[i]), 0);
  endtask

  initial begin
    int lit1 [4] = '{0, 2, 8, 10};
    int lit2 [4] = '{2, 4, 10, 12};
    int rd2  [4] = '{0, 1, 4, 5};
    int rd3  [8] = '{4, 4, 9, 9, 14, 14, 14, 14};
    int lit5 [6] = '{0, 3, 6, 7, 10, 13};
    int d0;
    for (int i = 0; i < 3; i++) begin
      start_a[i] = 1'b0;
      mode_a[i]  = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) chk_zero(i, $sformatf("reset%0d", i));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Decimate 4x4 by 2x2
    prep(0, 0, 0);
    for (int k = 0; k < 4; k++) chk($sformatf("t1_model_px%0d", k), 32'(exp_wr_q[k].data[7:0]), 32'(lit1[k]));
    go(0, 0);
    wait_done();

    // Average 4x4 by 2x2
    prep(0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t2_model_px%0d", k), 32'(exp_wr_q[k].data[7:0]), 32'(lit2[k]));
      chk($sformatf("t2_model_rd%0d", k), 32'(exp_q[k]), 32'(rd2[k]));
    end
    go(0, 1);
    wait_done();

    // Edge replication 5x3 by 2x2
    prep(1, 1, 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t3_model_rd_b20_%0d", k), 32'(exp_q[8 + k]), 32'(rd3[k]));
      chk($sformatf("t3_model_rd_b21_%0d", k), 32'(exp_q[20 + k]), 32'(rd3[4 + k]));
    end
    chk("t3_model_px2", 32'(exp_wr_q[2].data[7:0]), 6);
    chk("t3_model_px5", 32'(exp_wr_q[5].data[7:0]), 14);
    go(1, 1);
    wait_done();

    // Per-channel independence
    prep(0, 1, 1);
    chk("t4_model_ch0", 32'(exp_wr_q[0].data[7:0]), 255);
    chk("t4_model_ch1", 32'(exp_wr_q[0].data[15:8]), 0);
    chk("t4_model_ch2", 32'(exp_wr_q[0].data[23:16]), 97);
    go(0, 1);
    wait_done();

    // Asymmetric 7x2 by 3x1 decimate
    prep(2, 0, 0);
    for (int k = 0; k < 6; k++) chk($sformatf("t5_model_rd%0d", k), 32'(exp_q[k]), 32'(lit5[k]));
    go(2, 0);
    wait_done();

    // start pulsed mid-frame is ignored
    prep(0, 1, 0);
    go(0, 1);
    repeat (5) @(negedge clk);
    start_a[0] = 1'b1;
    @(negedge clk);
    start_a[0] = 1'b0;
    wait_done();

    // reset mid-frame aborts
    prep(0, 1, 0);
    go(0, 1);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero(0, "abort");
    exp_q.delete();
    exp_wr_q.delete();
    first_rd_cyc = -1;
    d0 = done_seen;
    repeat (20) @(negedge clk);
    chk("abort_no_done", 32'(done_seen - d0), 0);

    // full frame after abort
    prep(0, 1, 0);
    go(0, 1);
    wait_done();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
